// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipe_reg_chain register pipeline.
// Optional build macro: PIPE_REG_CHAIN_ZERO_DATA_EN (see pipe_reg_stage).
package pipe_reg_chain_pkg;

   localparam int c_def_nbits = 8;
   localparam int c_def_depth = 4;

   // Per-stage load control: load enable and the valid bit offered from upstream.
   typedef struct packed {
      logic ld;
      logic vin;
   } stage_ctl_t;

   // Width needed to count 0..depth occupied stages.
   function automatic int occ_width(input int depth);
      return (depth < 32'sd1) ? 32'sd1 : $clog2(depth + 32'sd1);
   endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: valid bit plus data register with load enable.
// With PIPE_REG_CHAIN_ZERO_DATA_EN defined, the data register is zeroed whenever the stage empties.
module pipe_reg_stage
   import pipe_reg_chain_pkg::*;
#(
   parameter int p_nbits = c_def_nbits
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               ld,
   input  logic               vin,
   input  logic [p_nbits-1:0] din,
   output logic               v,
   output logic [p_nbits-1:0] d
);

   logic               v_r;
   logic [p_nbits-1:0] d_r;
   logic [p_nbits-1:0] d_nxt_s;

   // Next data value: capture only real payloads; empty stages keep or zero their data.
   always_comb begin
      d_nxt_s = d_r;
      if (ld && vin && !flush) begin
         d_nxt_s = din;
`ifdef PIPE_REG_CHAIN_ZERO_DATA_EN
      end else if (flush || ld) begin
         d_nxt_s = '0;
`endif
      end else begin
         d_nxt_s = d_r;
      end
   end

   // Valid bit register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_r <= 1'b0;
      end else if (flush) begin
         v_r <= 1'b0;
      end else if (ld) begin
         v_r <= vin;
      end else begin
         v_r <= v_r;
      end
   end

   // Data register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_r <= '0;
      end else begin
         d_r <= d_nxt_s;
      end
   end

   assign v = v_r;
   assign d = d_r;

endmodule

// File: rtl/pipe_reg_chain.sv
// Valid/ready register chain of p_depth stages with flush and occupancy count.
// Optional build macro: PIPE_REG_CHAIN_ZERO_DATA_EN (zero data in empty stages).
module pipe_reg_chain
   import pipe_reg_chain_pkg::*;
#(
   parameter int p_nbits = c_def_nbits,
   parameter int p_depth = c_def_depth
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            in_val,
   output logic                            in_rdy,
   input  logic [p_nbits-1:0]              in_msg,
   output logic                            out_val,
   input  logic                            out_rdy,
   output logic [p_nbits-1:0]              out_msg,
   output logic [occ_width(p_depth)-1:0]   occ
);

   localparam int c_occ_w = occ_width(p_depth);

   logic               v_s   [p_depth];
   logic [p_nbits-1:0] d_s   [p_depth];
   logic [p_nbits-1:0] din_s [p_depth];
   stage_ctl_t         ctl_s [p_depth];
   logic [p_depth-1:0] r_s;
   logic               rdy_acc_s;
   logic               in_xfer_s;
   logic               out_xfer_s;
   logic [c_occ_w-1:0] occ_r;

   // Readiness ripples from the output end: a stage can load if empty or if its successor moves.
   always_comb begin
      r_s       = '0;
      rdy_acc_s = out_rdy;
      for (int i = p_depth - 1; i >= 0; i--) begin
         rdy_acc_s = !v_s[i] || rdy_acc_s;
         r_s[i]    = rdy_acc_s;
      end
   end

   for (genvar g = 0; g < p_depth; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign ctl_s[g] = '{ld: r_s[g], vin: in_val};
         assign din_s[g] = in_msg;
      end else begin : g_body
         assign ctl_s[g] = '{ld: r_s[g], vin: v_s[g-1]};
         assign din_s[g] = d_s[g-1];
      end

      pipe_reg_stage #(
         .p_nbits (p_nbits)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .ld    (ctl_s[g].ld),
         .vin   (ctl_s[g].vin),
         .din   (din_s[g]),
         .v     (v_s[g]),
         .d     (d_s[g])
      );
   end

   assign in_rdy     = r_s[0] && !flush;
   assign out_val    = v_s[p_depth-1];
   assign out_msg    = d_s[p_depth-1];
   assign in_xfer_s  = in_val && in_rdy;
   assign out_xfer_s = out_val && out_rdy;

   // Occupancy counter; an output handshake during flush still completes but the count goes to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_r <= '0;
      end else if (flush) begin
         occ_r <= '0;
      end else begin
         occ_r <= occ_r + c_occ_w'(in_xfer_s) - c_occ_w'(out_xfer_s);
      end
   end

   assign occ = occ_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (p_nbits=8, p_depth=3); honours PIPE_REG_CHAIN_ZERO_DATA_EN.
module tb_pipe_reg_chain;

   localparam int NB = 8;
   localparam int D  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_val;
   logic          in_rdy;
   logic [NB-1:0] in_msg;
   logic          out_val;
   logic          out_rdy;
   logic [NB-1:0] out_msg;
   logic [1:0]    occ;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [NB-1:0] exp_q [$];

   pipe_reg_chain #(
      .p_nbits (NB),
      .p_depth (D)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_msg  (in_msg),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_msg (out_msg),
      .occ     (occ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Input side: every accepted payload becomes an expected output.
   always @(negedge clk) begin
      #2;
      if (!rst && in_val && in_rdy) exp_q.push_back(in_msg);
   end

   // Output monitor: the chain is an order-preserving buffer of at most D entries.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         exp_q.delete();
      end else begin
         chk("occ", 32'(occ), 32'(exp_q.size()));
         chk("in_rdy", 32'(in_rdy), 32'(((exp_q.size() < D) || out_rdy) && !flush));
         if (exp_q.size() == 0) chk("out_val_empty", 32'(out_val), 32'd0);
         if (exp_q.size() == D) chk("out_val_full", 32'(out_val), 32'd1);
`ifdef PIPE_REG_CHAIN_ZERO_DATA_EN
         if (!out_val) chk("zero_data", 32'(out_msg), 32'd0);
`endif
         if (out_val && out_rdy && exp_q.size() > 0) begin
            chk("out_msg", 32'(out_msg), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
         if (flush) exp_q.delete();
      end
   end

   // Stream n payloads starting at base on consecutive cycles into an empty chain.
   task automatic run_stream(input int n, input logic [NB-1:0] base);
      logic [NB-1:0] e;
      out_rdy = 1'b1;
      for (int k = 0; k < n + D + 1; k++) begin
         @(posedge clk); #1;
         in_val = (k < n);
         in_msg = base + NB'(k);
         @(negedge clk); #3;
         chk("stream_out_val", 32'(out_val), 32'((k >= D) && (k < D + n)));
         if ((k >= D) && (k < D + n)) begin
            e = base + NB'(k - D);
            chk("stream_out_msg", 32'(out_msg), 32'(e));
         end
      end
      @(posedge clk); #1;
      in_val = 1'b0;
   endtask

   // Offer one payload and hold it until accepted (bounded).
   task automatic send_one(input logic [NB-1:0] msg);
      @(posedge clk); #1;
      in_val = 1'b1;
      in_msg = msg;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk); #3;
         if (in_rdy) begin
            @(posedge clk); #1;
            in_val = 1'b0;
            return;
         end
      end
      chk("send_accept", 32'(in_rdy), 32'd1);
      in_val = 1'b0;
   endtask

   task automatic wait_empty();
      for (int t = 0; t < 30; t++) begin
         @(negedge clk); #3;
         if (occ == 2'd0) break;
      end
      chk("drain_occ", 32'(occ), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_val = 1'b0; in_msg = 8'h00; out_rdy = 1'b0;
      #2;
      chk("rst_out_val", 32'(out_val), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_in_rdy", 32'(in_rdy), 32'd1);
      chk("rst_out_msg", 32'(out_msg), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_stream(1, 8'hA5);
      run_stream(6, 8'h01);

      // Fill and stall, then drain and accept in the same cycle.
      out_rdy = 1'b0;
      send_one(8'h10);
      send_one(8'h11);
      send_one(8'h12);
      @(negedge clk); #3;
      chk("full_occ", 32'(occ), 32'd3);
      chk("full_in_rdy", 32'(in_rdy), 32'd0);
      chk("stall_out_msg", 32'(out_msg), 32'h10);
      @(posedge clk); #1;
      in_val = 1'b1; in_msg = 8'h13; out_rdy = 1'b1;
      @(negedge clk); #3;
      chk("nobubble_in_rdy", 32'(in_rdy), 32'd1);
      chk("nobubble_out_val", 32'(out_val), 32'd1);
      chk("nobubble_out_msg", 32'(out_msg), 32'h10);
      @(posedge clk); #1;
      in_val = 1'b0;
      @(negedge clk); #3;
      chk("nobubble_occ", 32'(occ), 32'd3);
      wait_empty();

      // Flush with two entries held and an input offered.
      out_rdy = 1'b0;
      send_one(8'h20);
      send_one(8'h21);
      @(negedge clk); #3;
      chk("preflush_occ", 32'(occ), 32'd2);
      @(posedge clk); #1;
      flush = 1'b1; in_val = 1'b1; in_msg = 8'h22;
      @(negedge clk); #3;
      chk("flush_in_rdy", 32'(in_rdy), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_val = 1'b0;
      @(negedge clk); #3;
      chk("flush_occ", 32'(occ), 32'd0);
      chk("flush_out_val", 32'(out_val), 32'd0);

      // Asynchronous reset between edges with a full chain.
      send_one(8'h30);
      send_one(8'h31);
      send_one(8'h32);
      @(negedge clk); #3;
      chk("prerst_occ", 32'(occ), 32'd3);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_occ", 32'(occ), 32'd0);
      chk("arst_out_val", 32'(out_val), 32'd0);
      chk("arst_out_msg", 32'(out_msg), 32'd0);
      chk("arst_in_rdy", 32'(in_rdy), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      run_stream(2, 8'h40);

      // Data left behind in an emptied output stage.
      out_rdy = 1'b1;
      send_one(8'h7E);
      wait_empty();
      chk("drained_out_val", 32'(out_val), 32'd0);
`ifdef PIPE_REG_CHAIN_ZERO_DATA_EN
      chk("drained_out_msg", 32'(out_msg), 32'h00);
`else
      chk("drained_out_msg", 32'(out_msg), 32'h7E);
`endif

      // Random traffic with backpressure and occasional flush.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         in_val  = 1'($urandom_range(0, 1));
         in_msg  = 8'($urandom);
         out_rdy = ($urandom_range(0, 9) < 7);
         flush   = ($urandom_range(0, 29) == 0);
      end
      @(posedge clk); #1;
      in_val = 1'b0; flush = 1'b0; out_rdy = 1'b1;
      wait_empty();
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter p_nbits, default 8: payload width in bits, >= 1.
REQ-002 SHALL have parameter p_depth, default 4: number of register stages, >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-006 SHALL have port in_val, input, 1 bit: upstream payload valid.
REQ-007 SHALL have port in_rdy, output, 1 bit: chain can accept a payload this cycle.
REQ-008 SHALL have port in_msg, input, p_nbits: upstream payload.
REQ-009 SHALL have port out_val, output, 1 bit: last stage holds a valid payload.
REQ-010 SHALL have port out_rdy, input, 1 bit: downstream accepts a payload this cycle.
REQ-011 SHALL have port out_msg, output, p_nbits: last-stage payload.
REQ-012 SHALL have port occ, output, $clog2(p_depth+1) bits: number of valid stages.

Function
REQ-013 SHALL hold, per stage i (0..p_depth-1), a valid bit v[i] and a data register d[i]; stage 0 is the input end.
REQ-014 SHALL compute stage readiness combinationally: r[p_depth-1] = !v[p_depth-1] || out_rdy; r[i] = !v[i] || r[i+1].
REQ-015 SHALL drive in_rdy = r[0] && !flush.
REQ-016 SHALL drive out_val = v[p_depth-1] and out_msg = d[p_depth-1].
REQ-017 SHALL, when r[i] is high, load stage i from stage i-1 (stage 0: in_val/in_msg): v[i] <= v[i-1], d[i] <= d[i-1] only if v[i-1].
REQ-018 SHALL hold v[i] and d[i] unchanged when r[i] is low (stall).
REQ-019 SHALL give a latency of exactly p_depth cycles from an in_val&&in_rdy transfer to out_val, with out_rdy held high.
REQ-020 SHALL sustain a throughput of one transfer per cycle when out_rdy is held high.
REQ-021 SHALL preserve payload order; no payload is duplicated or dropped except by flush or reset.
REQ-022 SHALL, when full (all v high) with out_rdy low, drive in_rdy low.
REQ-023 SHALL, when full and out_rdy high, accept a new input in the same cycle the output drains (no bubble).
REQ-024 SHALL, with flush high at a clock edge, clear every v[i] at that edge and accept no input; an output handshake in that cycle still completes.
REQ-025 SHALL update occ at every edge: occ_next = occ + in_xfer - out_xfer; flush forces occ_next = 0.
REQ-026 SHALL keep occ in range 0..p_depth at all times.

Reset
REQ-027 SHALL, while rst is high, immediately force all v[i] = 0, all d[i] = 0 and occ = 0, independent of clk.
REQ-028 SHALL therefore drive out_val = 0, out_msg = 0 and occ = 0 during and after reset, with in_rdy = 1 unless flush is high.
REQ-029 SHALL discard all in-flight payloads on a mid-operation reset; the first edge after rst falls behaves as from an empty chain.

Configuration
REQ-030 SHALL support macro PIPE_REG_CHAIN_ZERO_DATA_EN.
REQ-031 SHALL, with the macro defined, load d[i] with 0 whenever v[i] becomes 0, so out_msg = 0 whenever out_val = 0.
REQ-032 SHALL, without the macro, leave d[i] holding stale data when a stage empties; only v[i] is cleared.

Structure
REQ-033 SHALL place the occ width constant function and any shared stage-state typedef in package pipe_reg_chain_pkg.
REQ-034 SHALL implement one stage as sub-module pipe_reg_stage (valid bit plus data register with load enable), instantiated p_depth times via generate.

Verification
REQ-035 SHALL cover, with p_nbits=8 and p_depth=3: reset release -> out_val=0, occ=0, in_rdy=1; send 0xA5 with out_rdy=1 -> out_val=1, out_msg=0xA5 exactly 3 cycles later.
REQ-036 SHALL cover back-to-back stream: send 0x01..0x06 on consecutive cycles with out_rdy=1 -> outputs 0x01..0x06 on consecutive cycles starting 3 cycles later.
REQ-037 SHALL cover fill and stall: out_rdy=0, send 0x10,0x11,0x12,0x13 -> occ=3 and in_rdy=0 after three transfers; then raise out_rdy -> 0x10 drains and 0x13 is accepted in the same cycle.
REQ-038 SHALL cover flush: occ=2 holding 0x20,0x21, assert flush one cycle with in_val=1 -> next cycle occ=0, out_val=0, input not accepted.
REQ-039 SHALL cover async reset mid-stream: assert rst between clock edges with occ=3 -> occ=0 and out_val=0 before the next edge.
REQ-040 SHALL cover both macro builds: after 0x7E drains, out_msg=0x00 with PIPE_REG_CHAIN_ZERO_DATA_EN defined and out_msg=0x7E without it.
